// File: rtl/present_round_ctrl.sv
// PRESENT-80 round controller: sequences AddRoundKey / external S-layer / external P-layer over 31 rounds.
// One round every three cycles; done pulses 94 edges after accept; start is ignored whenever busy.
module present_round_ctrl #(
    parameter int SIZE     = 64,
    parameter int KEY_BITS = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [SIZE-1:0]     plaintext,
    input  logic [KEY_BITS-1:0] key,
    output logic [SIZE-1:0]     sl_in,
    input  logic [SIZE-1:0]     sl_out,
    output logic [SIZE-1:0]     pl_original,
    input  logic [SIZE-1:0]     pl_permuted,
    output logic                pl_done,
    output logic                busy,
    output logic                done,
    output logic [SIZE-1:0]     ciphertext
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDKEY = 3'd1,
        S_SBOX   = 3'd2,
        S_PLAYER = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [SIZE-1:0]     blk_q, blk_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [4:0]          round_q, round_d;
    logic [SIZE-1:0]     ct_q, ct_d;

    logic [SIZE-1:0]     round_key;
    logic [KEY_BITS-1:0] key_rot;
    logic [KEY_BITS-1:0] key_sched;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Round key is the top SIZE bits of the current key register.
    assign round_key = key_q[KEY_BITS-1 -: SIZE];

    always_comb begin
        key_rot   = (key_q << 61) | (key_q >> (KEY_BITS - 61));
        key_sched = key_rot;
        key_sched[KEY_BITS-1 -: 4] = sbox4(key_rot[KEY_BITS-1 -: 4]);
        key_sched[19:15] = key_rot[19:15] ^ round_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            round_q <= round_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ADDKEY;
            S_ADDKEY: state_d = S_SBOX;
            S_SBOX:   state_d = S_PLAYER;
            S_PLAYER: state_d = (round_q < LAST_ROUND) ? S_ADDKEY : S_FINAL;
            S_FINAL:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_d   = blk_q;
        key_d   = key_q;
        round_d = round_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d   = plaintext;
                    key_d   = key;
                    round_d = 5'd1;
                end
            end
            S_ADDKEY: blk_d = blk_q ^ round_key;
            S_SBOX:   blk_d = sl_out;
            S_PLAYER: begin
                blk_d = pl_permuted;
                key_d = key_sched;
                // Saturate so the 5-bit counter never wraps after the last round.
                round_d = (round_q == LAST_ROUND) ? round_q : round_q + 5'd1;
            end
            S_FINAL:  ct_d = blk_q ^ round_key;
            default: ;
        endcase
    end

    always_comb begin
        sl_in       = blk_q;
        pl_original = blk_q;
        pl_done     = (state_q == S_PLAYER);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        ciphertext  = ct_q;
    end

endmodule

// File: doc/present_round_ctrl.md
PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 Parameter SIZE, 64, cipher block width in bits.
REQ-002 Parameter KEY_BITS, 80, key register width in bits.
REQ-003 Parameter ROUNDS, 31, number of full rounds.
REQ-004 The block SHALL use one clock, Clock, and an asynchronous, active-high reset, Reset.
REQ-005 Clock  input  1  rising-edge clock for all state.
REQ-006 Reset  input  1  asynchronous, active-high; clears all state.
REQ-007 start  input  1  request to encrypt; sampled only in IDLE.
REQ-008 plaintext  input  SIZE  block, latched on the accept edge.
REQ-009 key  input  KEY_BITS  cipher key, latched on the accept edge.
REQ-010 sl_in  output  SIZE  operand to the external combinational S-layer.
REQ-011 sl_out  input  SIZE  S-layer result.
REQ-012 pl_original  output  SIZE  operand to the external combinational P-layer.
REQ-013 pl_permuted  input  SIZE  P-layer result.
REQ-014 pl_done  output  1  high only in PLAYER state; drives the P-layer done input.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  single-cycle completion pulse.
REQ-017 ciphertext  output  SIZE  result register; held until the next accept.

Function
REQ-018 The FSM SHALL have the states IDLE, ADDKEY, SBOX, PLAYER, FINAL and DONE, each lasting exactly one cycle except IDLE.
REQ-019 Accept: in IDLE with start=1, the state register SHALL load plaintext, the key register SHALL load key, the round counter SHALL be set to 1 and the FSM SHALL go to ADDKEY.
REQ-020 ADDKEY: state <= state XOR key[79:16]; the FSM SHALL go to SBOX.
REQ-021 SBOX: sl_in = state; state <= sl_out; the FSM SHALL go to PLAYER.
REQ-022 PLAYER: pl_original = state; state <= pl_permuted; key <= schedule(key, round); round <= round+1; the FSM SHALL go to ADDKEY if round<ROUNDS and to FINAL otherwise.
REQ-023 schedule: rotate the key left by 61, apply the internal 4-bit PRESENT S-box (C56B90AD3EF84712) to bits [79:76], then XOR bits [19:15] with the 5-bit round counter value before increment.
REQ-024 FINAL: ciphertext <= state XOR key[79:16] (round key 32); the FSM SHALL go to DONE.
REQ-025 DONE: done=1 for this one cycle only; the FSM SHALL go to IDLE.
REQ-026 Latency: done SHALL be high in the cycle following the 94th rising edge after the accept edge; the block SHALL not accept a new start before done falls.
REQ-027 start while busy=1, including the DONE cycle, SHALL be ignored and SHALL not be queued.
REQ-028 sl_in and pl_original SHALL always be driven with the state register; pl_done SHALL be 0 outside PLAYER.
REQ-029 Changes to plaintext or key after the accept edge SHALL not affect the running encryption.
REQ-030 The round counter SHALL be 5 bits and SHALL never exceed 31; it SHALL not wrap during an operation.

Reset
REQ-031 Reset=1 SHALL immediately force the FSM to IDLE and clear state, key, round, ciphertext, busy, done and pl_done to 0, independent of Clock.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done pulse, and ciphertext SHALL read 0.
REQ-033 After Reset falls, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 plaintext 0000000000000000, key 0 -> ciphertext 5579C1387B228445, done pulse one cycle, 94 edges after accept.
REQ-035 plaintext 0, key FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049; plaintext FFFFFFFFFFFFFFFF, key 0 -> A112FFC72F68417B.
REQ-036 plaintext all-F, key all-F -> 3333DCD3213210D2; then hold start=1 continuously -> back-to-back operations, each accepted in the IDLE cycle after done.
REQ-037 start pulsed during round 10 and during the DONE cycle -> ignored; the result matches REQ-034; plaintext and key are changed mid-run with no effect.
REQ-038 Reset asserted at round 15 -> busy=0, ciphertext=0, no done pulse; a fresh start then gives the correct result.
REQ-039 pl_done is checked every cycle -> high in exactly 31 cycles per operation, all in PLAYER state.
